// File: rtl/pong_pkg.sv
// Shared definitions for the Pong frame engine: game states, colours, default screen geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_BALL   = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t RGB_PADDLE = '{r: 4'h0, g: 4'h0, b: 4'hF};
  localparam rgb_t RGB_LINE   = '{r: 4'h8, g: 4'h8, b: 4'h8};
  localparam rgb_t RGB_BG     = '{r: 4'hC, g: 4'hF, b: 4'hD};

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/pong_frame_engine_if.sv
// Buttons, raster position in, colour and score status out.
interface pong_frame_engine_if #(
  parameter int SCORE_W = 4
);
  logic               p1up;
  logic               p1down;
  logic               p2up;
  logic               p2down;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               display_on;
  logic [3:0]         r;
  logic [3:0]         g;
  logic [3:0]         b;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic               game_over;

  modport master (
    output p1up, p1down, p2up, p2down, hpos, vpos, display_on,
    input  r, g, b, score_p1, score_p2, game_over
  );

  modport slave (
    input  p1up, p1down, p2up, p2down, hpos, vpos, display_on,
    output r, g, b, score_p1, score_p2, game_over
  );
endinterface

// File: rtl/paddle_motion.sv
// One paddle's vertical position, stepped once per tick from its up/down buttons and clamped on screen.
module paddle_motion #(
  parameter int PADDLE_H     = 96,
  parameter int PADDLE_SPEED = 4,
  parameter int V_ACTIVE     = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0]         Y_RST = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic signed [10:0] STEP  = 11'(PADDLE_SPEED);

  logic [9:0]         y_reg;
  logic signed [10:0] y_cur;
  logic signed [10:0] y_next;

  assign y_cur = signed'({1'b0, y_reg});
  assign y     = y_reg;

  // Signed 11-bit step so an overshoot past either edge clamps instead of wrapping.
  always_comb begin
    y_next = y_cur;
    if (up && !down) begin
      y_next = (y_cur - STEP < 11'sd0) ? 11'sd0 : y_cur - STEP;
    end else if (down && !up) begin
      y_next = (y_cur + STEP > Y_MAX) ? Y_MAX : y_cur + STEP;
    end
  end

  // Position only moves on the frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_reg <= Y_RST;
    end else if (tick) begin
      y_reg <= y_next[9:0];
    end
  end
endmodule

// File: rtl/pong_frame_engine.sv
// Two-player Pong core: paddles, ball, scoring, game FSM and a one-cycle registered pixel mux.
module pong_frame_engine
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int PADDLE_H     = 96,
  parameter int PADDLE_W     = 15,
  parameter int PADDLE_X     = 30,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input logic                clk,
  input logic                reset,
  pong_frame_engine_if.slave bus
);
  localparam int SC_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [SC_W-1:0]    SERVE_LAST = SC_W'(SERVE_FRAMES - 1);
  localparam logic [9:0]         BX_C       = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]         BY_C       = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [10:0] BSPD       = 11'(BALL_SPEED);
  localparam logic signed [10:0] BSZ        = 11'(BALL_SIZE);
  localparam logic signed [10:0] PH         = 11'(PADDLE_H);
  localparam logic signed [10:0] L_EDGE     = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] R_LIMIT    = 11'(H_ACTIVE - PADDLE_X - PADDLE_W - BALL_SIZE);
  localparam logic signed [10:0] Y_MAXB     = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] X_MISS_R   = 11'(H_ACTIVE - BALL_SIZE - BALL_SPEED);

  game_state_t        state_reg, state_next;
  logic [SC_W-1:0]    serve_cnt_reg, serve_cnt_next;
  logic [9:0]         bx_reg, bx_next, by_reg, by_next;
  logic               dx_neg_reg, dx_neg_next, dy_neg_reg, dy_neg_next;
  logic               point_p1_reg, point_p1_next;
  logic [SCORE_W-1:0] score_p1_reg, score_p1_next, score_p2_reg, score_p2_next;
  logic [SCORE_W-1:0] score_won;
  rgb_t               rgb_reg, rgb_next;

  logic               frame_tick, paddle_tick;
  logic signed [10:0] bx_s, by_s, nx, ny;
  logic [10:0]        h11, v11;
  logic [1:0]         up_v, down_v, overlap, in_pad;
  logic [9:0]         pad_y [2];
  logic               in_ball;

  assign frame_tick  = (bus.hpos == 10'd0) && (bus.vpos == 10'(V_ACTIVE));
  assign paddle_tick = frame_tick && (state_reg != ST_OVER);
  assign bx_s   = signed'({1'b0, bx_reg});
  assign by_s   = signed'({1'b0, by_reg});
  assign nx     = dx_neg_reg ? bx_s - BSPD : bx_s + BSPD;
  assign ny     = dy_neg_reg ? by_s - BSPD : by_s + BSPD;
  assign h11    = {1'b0, bus.hpos};
  assign v11    = {1'b0, bus.vpos};
  assign up_v   = {bus.p2up, bus.p1up};
  assign down_v = {bus.p2down, bus.p1down};

  // Index 0 is the left player, index 1 the mirrored right player.
  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    localparam logic [10:0] PX = 11'((gi == 0) ? PADDLE_X : H_ACTIVE - PADDLE_X - PADDLE_W);
    logic signed [10:0] py_s;

    paddle_motion #(
      .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED), .V_ACTIVE(V_ACTIVE)
    ) u_paddle (
      .clk(clk), .reset(reset), .tick(paddle_tick),
      .up(up_v[gi]), .down(down_v[gi]), .y(pad_y[gi])
    );

    assign py_s        = signed'({1'b0, pad_y[gi]});
    assign overlap[gi] = (by_s + BSZ - 11'sd1 >= py_s) && (by_s <= py_s + PH - 11'sd1);
    assign in_pad[gi]  = (h11 >= PX) && (h11 < PX + 11'(PADDLE_W)) &&
                         (v11 >= {1'b0, pad_y[gi]}) && (v11 < {1'b0, pad_y[gi]} + 11'(PADDLE_H));
  end

  assign score_won = (point_p1_reg ? score_p1_reg : score_p2_reg) + SCORE_W'(1);

  // Game state register and ball/score state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_SERVE;
      serve_cnt_reg <= '0;
      bx_reg        <= BX_C;
      by_reg        <= BY_C;
      dx_neg_reg    <= 1'b0;
      dy_neg_reg    <= 1'b0;
      point_p1_reg  <= 1'b0;
      score_p1_reg  <= '0;
      score_p2_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      serve_cnt_reg <= serve_cnt_next;
      bx_reg        <= bx_next;
      by_reg        <= by_next;
      dx_neg_reg    <= dx_neg_next;
      dy_neg_reg    <= dy_neg_next;
      point_p1_reg  <= point_p1_next;
      score_p1_reg  <= score_p1_next;
      score_p2_reg  <= score_p2_next;
    end
  end

  // Next state: serve countdown, ball flight with wall/paddle bounces, scoring; only on frame_tick.
  always_comb begin
    state_next     = state_reg;
    serve_cnt_next = serve_cnt_reg;
    bx_next        = bx_reg;
    by_next        = by_reg;
    dx_neg_next    = dx_neg_reg;
    dy_neg_next    = dy_neg_reg;
    point_p1_next  = point_p1_reg;
    score_p1_next  = score_p1_reg;
    score_p2_next  = score_p2_reg;
    if (frame_tick) begin
      case (state_reg)
        ST_SERVE: begin
          bx_next = BX_C;
          by_next = BY_C;
          if (serve_cnt_reg == SERVE_LAST) begin
            serve_cnt_next = '0;
            state_next     = ST_PLAY;
          end else begin
            serve_cnt_next = serve_cnt_reg + SC_W'(1);
          end
        end
        ST_PLAY: begin
          // A miss freezes the ball for this frame; POINT recentres it next frame.
          if (dx_neg_reg && (bx_s < BSPD)) begin
            point_p1_next = 1'b0;
            state_next    = ST_POINT;
          end else if (!dx_neg_reg && (bx_s > X_MISS_R)) begin
            point_p1_next = 1'b1;
            state_next    = ST_POINT;
          end else begin
            if (ny < 11'sd0) begin
              by_next     = 10'd0;
              dy_neg_next = 1'b0;
            end else if (ny > Y_MAXB) begin
              by_next     = Y_MAXB[9:0];
              dy_neg_next = 1'b1;
            end else begin
              by_next = ny[9:0];
            end
            bx_next = nx[9:0];
            if (dx_neg_reg && (bx_s >= L_EDGE) && (nx < L_EDGE) && overlap[0]) begin
              bx_next     = L_EDGE[9:0];
              dx_neg_next = 1'b0;
            end
            if (!dx_neg_reg && (bx_s <= R_LIMIT) && (nx > R_LIMIT) && overlap[1]) begin
              bx_next     = R_LIMIT[9:0];
              dx_neg_next = 1'b1;
            end
          end
        end
        ST_POINT: begin
          if (point_p1_reg) score_p1_next = score_won;
          else              score_p2_next = score_won;
          if (score_won == SCORE_W'(WIN_SCORE)) begin
            state_next = ST_OVER;
          end else begin
            bx_next     = BX_C;
            by_next     = BY_C;
            dx_neg_next = !point_p1_reg;
            state_next  = ST_SERVE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ball = (h11 >= {1'b0, bx_reg}) && (h11 < {1'b0, bx_reg} + 11'(BALL_SIZE)) &&
                   (v11 >= {1'b0, by_reg}) && (v11 < {1'b0, by_reg} + 11'(BALL_SIZE));

  // Pixel colour by priority: ball, paddles, dashed centre line, background.
  always_comb begin
    rgb_next = RGB_BG;
    if (!bus.display_on)                                          rgb_next = RGB_BLACK;
    else if (in_ball)                                             rgb_next = RGB_BALL;
    else if (|in_pad)                                             rgb_next = RGB_PADDLE;
    else if ((bus.hpos == 10'(H_ACTIVE / 2)) && !bus.vpos[3])     rgb_next = RGB_LINE;
  end

  // Colour output register, one clock behind hpos/vpos.
  always_ff @(posedge clk) begin
    if (reset) rgb_reg <= RGB_BLACK;
    else       rgb_reg <= rgb_next;
  end

  assign bus.r         = rgb_reg.r;
  assign bus.g         = rgb_reg.g;
  assign bus.b         = rgb_reg.b;
  assign bus.score_p1  = score_p1_reg;
  assign bus.score_p2  = score_p2_reg;
  assign bus.game_over = (state_reg == ST_OVER);
endmodule

// File: tb/tb_pong_frame_engine.sv
// Bench for pong_frame_engine: drives frame ticks and pixel probes directly, checks against a game model.
module tb_pong_frame_engine;
  localparam int HA = 640, VA = 480, PH = 96, PW = 15, PX = 30, PSPD = 4;
  localparam int BS = 8, BSPD = 4, SERVE = 60, WIN = 7;
  localparam int RPX = HA - PX - PW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pong_frame_engine_if #(.SCORE_W(4)) bus();
  pong_frame_engine dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: positions, velocities as signed pixel steps, serve/point bookkeeping.
  int m_py[2];
  int m_bx, m_by, m_vx, m_vy;
  int m_s[2];
  bit m_over, m_playing;
  int m_serve_done;
  int m_pending;  // 0 none, 1 player 1 scored, 2 player 2 scored

  typedef struct {
    int         h;
    int         v;
    bit         de;
    logic [11:0] rgb;
  } vec_t;
  vec_t tbl[18];

  function automatic void model_reset();
    m_py[0] = (VA - PH) / 2; m_py[1] = (VA - PH) / 2;
    m_bx = (HA - BS) / 2; m_by = (VA - BS) / 2;
    m_vx = BSPD; m_vy = BSPD;
    m_s[0] = 0; m_s[1] = 0;
    m_over = 0; m_playing = 0; m_serve_done = 0; m_pending = 0;
  endfunction

  function automatic bit overlaps(int py);
    return (m_by + BS - 1 >= py) && (m_by <= py + PH - 1);
  endfunction

  function automatic int padx(int p);
    return (p == 0) ? PX : RPX;
  endfunction

  function automatic void model_frame(bit u1, bit d1, bit u2, bit d2);
    int old_py[2];
    bit up[2], dn[2];
    int nx, ny;
    if (m_over) return;
    old_py = m_py;
    up[0] = u1; dn[0] = d1; up[1] = u2; dn[1] = d2;
    for (int p = 0; p < 2; p++) begin
      if (up[p] && !dn[p]) m_py[p] = (m_py[p] - PSPD < 0) ? 0 : m_py[p] - PSPD;
      else if (dn[p] && !up[p]) m_py[p] = (m_py[p] + PSPD > VA - PH) ? VA - PH : m_py[p] + PSPD;
    end
    if (m_pending != 0) begin
      m_s[m_pending-1] = m_s[m_pending-1] + 1;
      if (m_s[m_pending-1] == WIN) m_over = 1;
      else begin
        m_bx = (HA - BS) / 2; m_by = (VA - BS) / 2;
        m_vx = (m_pending == 1) ? BSPD : -BSPD;
        m_playing = 0; m_serve_done = 0;
      end
      m_pending = 0;
    end else if (!m_playing) begin
      m_serve_done++;
      if (m_serve_done == SERVE) m_playing = 1;
    end else if (m_vx < 0 && m_bx < BSPD) begin
      m_pending = 2;
    end else if (m_vx > 0 && m_bx > HA - BS - BSPD) begin
      m_pending = 1;
    end else begin
      nx = m_bx + m_vx; ny = m_by + m_vy;
      if (ny < 0) begin ny = 0; m_vy = BSPD; end
      else if (ny > VA - BS) begin ny = VA - BS; m_vy = -BSPD; end
      if (m_vx < 0 && m_bx >= PX + PW && nx < PX + PW && overlaps(old_py[0])) begin
        nx = PX + PW; m_vx = BSPD;
      end else if (m_vx > 0 && m_bx + BS <= RPX && nx + BS > RPX && overlaps(old_py[1])) begin
        nx = RPX - BS; m_vx = -BSPD;
      end
      m_bx = nx; m_by = ny;
    end
  endfunction

  function automatic logic [11:0] exp_color(int h, int v, bit de);
    if (!de) return 12'h000;
    if (h >= m_bx && h < m_bx + BS && v >= m_by && v < m_by + BS) return 12'hFFF;
    for (int p = 0; p < 2; p++)
      if (h >= padx(p) && h < padx(p) + PW && v >= m_py[p] && v < m_py[p] + PH) return 12'h00F;
    if (h == HA / 2 && ((v / 8) % 2) == 0) return 12'h888;
    return 12'hCFD;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int h, input int v, input bit de);
    bus.hpos = 10'(h); bus.vpos = 10'(v); bus.display_on = de;
    @(posedge clk); #1;
  endtask

  task automatic probe_exp(input string name, input int h, input int v, input bit de, input logic [11:0] exp);
    cyc(h, v, de);
    $display("probe %-12s h=%0d v=%0d de=%0d rgb=%h exp=%h", name, h, v, de, {bus.r, bus.g, bus.b}, exp);
    check(name, int'({bus.r, bus.g, bus.b}), int'(exp));
  endtask

  task automatic probe(input string name, input int h, input int v, input bit de);
    cyc(h, v, de);
    check(name, int'({bus.r, bus.g, bus.b}), int'(exp_color(h, v, de)));
  endtask

  // One frame: tick with the given buttons, then pixel probes at model-derived spots.
  task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2);
    int p;
    bus.p1up = u1; bus.p1down = d1; bus.p2up = u2; bus.p2down = d2;
    cyc(0, VA, 0);
    model_frame(u1, d1, u2, d2);
    check("blank_rgb", int'({bus.r, bus.g, bus.b}), 0);
    check("score_p1", int'(bus.score_p1), m_s[0]);
    check("score_p2", int'(bus.score_p2), m_s[1]);
    check("game_over", int'(bus.game_over), int'(m_over));
    probe("ball_tl", m_bx, m_by, 1);
    probe("ball_br", m_bx + BS - 1, m_by + BS - 1, 1);
    probe("ball_out", (m_bx > 0) ? m_bx - 1 : m_bx + BS, m_by, 1);
    p = int'($urandom_range(0, 1));
    probe("pad_in", padx(p) + int'($urandom_range(0, PW - 1)), m_py[p] + int'($urandom_range(0, PH - 1)), 1);
    probe("pad_out", padx(p), (m_py[p] > 0) ? m_py[p] - 1 : m_py[p] + PH, 1);
    probe("rand_pix", int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_frame();
    logic [3:0] btn;
    btn = 4'($urandom_range(0, 15));
    frame(btn[0], btn[1], btn[2], btn[3]);
  endtask

  task automatic reset_check(input string tag);
    reset = 1'b1;
    cyc(316, 236, 1);
    $display("reset %s rgb=%h s1=%0d s2=%0d over=%0d", tag, {bus.r, bus.g, bus.b},
             bus.score_p1, bus.score_p2, bus.game_over);
    check({tag, "_rgb"}, int'({bus.r, bus.g, bus.b}), 0);
    check({tag, "_s1"}, int'(bus.score_p1), 0);
    check({tag, "_s2"}, int'(bus.score_p2), 0);
    check({tag, "_over"}, int'(bus.game_over), 0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{316, 236, 1'b1, 12'hFFF};
    tbl[1]  = '{323, 243, 1'b1, 12'hFFF};
    tbl[2]  = '{324, 236, 1'b1, 12'hCFD};
    tbl[3]  = '{315, 243, 1'b1, 12'hCFD};
    tbl[4]  = '{320, 240, 1'b1, 12'hFFF};
    tbl[5]  = '{320, 244, 1'b1, 12'h888};
    tbl[6]  = '{320, 0,   1'b1, 12'h888};
    tbl[7]  = '{320, 8,   1'b1, 12'hCFD};
    tbl[8]  = '{320, 16,  1'b1, 12'h888};
    tbl[9]  = '{30,  192, 1'b1, 12'h00F};
    tbl[10] = '{44,  287, 1'b1, 12'h00F};
    tbl[11] = '{30,  191, 1'b1, 12'hCFD};
    tbl[12] = '{45,  200, 1'b1, 12'hCFD};
    tbl[13] = '{595, 287, 1'b1, 12'h00F};
    tbl[14] = '{609, 192, 1'b1, 12'h00F};
    tbl[15] = '{610, 200, 1'b1, 12'hCFD};
    tbl[16] = '{594, 250, 1'b1, 12'hCFD};
    tbl[17] = '{316, 236, 1'b0, 12'h000};

    bus.p1up = 0; bus.p1down = 0; bus.p2up = 0; bus.p2down = 0;
    bus.hpos = 10'd100; bus.vpos = 10'd100; bus.display_on = 1'b0;
    model_reset();
    reset_check("rst0");
    reset_check("rst1");

    // Idle serve: everything sits at its reset position.
    for (int f = 0; f < 10; f++) frame(0, 0, 0, 0);
    for (int i = 0; i < 18; i++) probe_exp($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].rgb);

    // Left paddle driven into the top edge and held there.
    for (int f = 0; f < 60; f++) frame(1, 0, 0, 0);
    probe_exp("p1_top", 30, 0, 1, 12'h00F);
    probe_exp("p1_bot", 44, 95, 1, 12'h00F);
    probe_exp("p1_below", 30, 96, 1, 12'hCFD);

    // Both buttons together leave the right paddle in place.
    for (int f = 0; f < 5; f++) frame(0, 0, 1, 1);
    probe_exp("p2_top", 595, 192, 1, 12'h00F);
    probe_exp("p2_above", 595, 191, 1, 12'hCFD);
    probe_exp("p2_bot", 609, 287, 1, 12'h00F);
    probe_exp("p2_below", 609, 288, 1, 12'hCFD);

    // Random play to the end of a game.
    for (int f = 0; f < 9000 && !m_over; f++) rand_frame();
    if (!m_over) begin
      n_cmp++; n_bad++;
      $display("FAIL game_bound: no winner after 9000 frames, score %0d-%0d", m_s[0], m_s[1]);
    end
    $display("game end score_p1=%0d score_p2=%0d over=%0d", bus.score_p1, bus.score_p2, bus.game_over);
    check("winner_score", int'((bus.score_p1 > bus.score_p2) ? bus.score_p1 : bus.score_p2), WIN);
    check("over_flag", int'(bus.game_over), 1);

    // Frozen in OVER regardless of buttons.
    for (int f = 0; f < 5; f++) rand_frame();

    // Reset out of OVER, then reset again in the middle of play.
    reset_check("rst_over");
    probe_exp("ctr_ball", 316, 236, 1, 12'hFFF);
    for (int f = 0; f < 75; f++) rand_frame();
    reset_check("rst_play");
    probe_exp("rp_ball", 316, 236, 1, 12'hFFF);
    probe_exp("rp_p1", 30, 192, 1, 12'h00F);
    probe_exp("rp_p2", 609, 287, 1, 12'h00F);
    for (int f = 0; f < 5; f++) rand_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
